// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Purpose  : Shared definitions for the memory stage: access-size encodings,
//            the memory-stage FSM state type and a size-normalising helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  // Access size encodings carried on the 2-bit size field
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_DBL  = 2'b11;

  // Memory-stage sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A double access cannot exist on a 32-bit data path; it degrades to a word.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_w);
    logic [1:0] r;
    r = size;
    if ((data_w == 32) && (size == SIZE_DBL)) r = SIZE_WORD;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
//------------------------------------------------------------------------------
// Module   : mem_stage_if
// Purpose  : Bundles the memory stage's pipeline request, result and memory
//            bus signals.
//   slave  : view taken by the memory stage itself
//   master : view taken by the surrounding pipeline / memory model
// Signals  : in_valid/in_ready handshake, mem_read/mem_write/size/
//            load_unsigned/mem_addr/mem_write_data command, sideband
//            (branch/reg_write/write_reg/branch_addr/reg_write_data) in and out,
//            bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb request,
//            bus_gnt/bus_rvalid/bus_rdata response, out_valid result strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
);
  // Pipeline request
  logic                in_valid;
  logic                in_ready;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          size;
  logic                load_unsigned;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_write_data;
  logic                branch_in;
  logic                reg_write_in;
  logic [REG_W-1:0]    write_reg_in;
  logic [ADDR_W-1:0]   branch_addr_in;
  logic [DATA_W-1:0]   reg_write_data_in;

  // Memory bus
  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic                bus_gnt;
  logic                bus_rvalid;
  logic [DATA_W-1:0]   bus_rdata;

  // Results
  logic                out_valid;
  logic                branch_out;
  logic                reg_write_out;
  logic [REG_W-1:0]    write_reg_out;
  logic [ADDR_W-1:0]   branch_addr_out;
  logic [DATA_W-1:0]   reg_write_data_out;

  modport slave (
    input  in_valid, mem_read, mem_write, size, load_unsigned, mem_addr,
           mem_write_data, branch_in, reg_write_in, write_reg_in,
           branch_addr_in, reg_write_data_in,
    output in_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output out_valid, branch_out, reg_write_out, write_reg_out,
           branch_addr_out, reg_write_data_out
  );

  modport master (
    output in_valid, mem_read, mem_write, size, load_unsigned, mem_addr,
           mem_write_data, branch_in, reg_write_in, write_reg_in,
           branch_addr_in, reg_write_data_in,
    input  in_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  out_valid, branch_out, reg_write_out, write_reg_out,
           branch_addr_out, reg_write_data_out
  );

endinterface

`default_nettype wire

// File: rtl/load_align.sv
//------------------------------------------------------------------------------
// Module   : load_align
// Purpose  : Combinational load data alignment: picks the addressed lane out
//            of the read bus word and sign- or zero-extends it to DATA_W.
// Ports    : i_rdata    - raw read data from the bus
//            i_lane     - byte lane of the access (already size aligned)
//            i_size     - access size (already normalised for DATA_W)
//            i_unsigned - 1 = zero-extend, 0 = sign-extend
//            o_data     - aligned, extended load value
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  wire logic [DATA_W-1:0] i_rdata,
  input  wire logic [LANE_W-1:0] i_lane,
  input  wire logic [1:0]        i_size,
  input  wire logic              i_unsigned,
  output logic      [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic              w_sign;
  int                w_nbits;

  always_comb begin
    // Bring the addressed lane down to bit 0
    w_shifted = i_rdata >> {i_lane, 3'b000};

    w_nbits = 8 << i_size;
    if (w_nbits > DATA_W) w_nbits = DATA_W;

    case (i_size)
      SIZE_BYTE: w_sign = w_shifted[7];
      SIZE_HALF: w_sign = w_shifted[15];
      SIZE_DBL:  w_sign = w_shifted[DATA_W-1];
      default:   w_sign = w_shifted[31];
    endcase

    o_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_data[i] = (i < w_nbits) ? w_shifted[i] : (w_sign & ~i_unsigned);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_stage
// Purpose  : Pipeline memory stage. Accepts one request at a time, issues a
//            byte/half/word/double load or store on a req/gnt + rvalid bus,
//            aligns and extends load data, and presents the registered
//            results (plus pass-through sideband) with a one-cycle out_valid.
// Ports    : clk            - clock, rising edge
//            rst_n          - asynchronous active-low reset
//            io             - mem_stage_if.slave (request, bus, results)
//            misalign_fault - only with MEM_STAGE_MISALIGN_TRAP_EN; pulses
//                             with out_valid for a trapped misaligned access
// Config   : MEM_STAGE_MISALIGN_TRAP_EN - trap misaligned half/word/double
//            accesses instead of rounding the address down.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mem_stage_if.slave  io
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  state_t              r_state;
  state_t              w_next;

  // Captured request
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LANES-1:0]    r_wstrb;
  logic                r_branch;
  logic                r_reg_write;
  logic [REG_W-1:0]    r_write_reg;
  logic [ADDR_W-1:0]   r_branch_addr;
  logic [DATA_W-1:0]   r_rwd;

  // Result registers
  logic                r_out_branch;
  logic                r_out_reg_write;
  logic [REG_W-1:0]    r_out_write_reg;
  logic [ADDR_W-1:0]   r_out_branch_addr;
  logic [DATA_W-1:0]   r_out_rwd;
  logic                r_fault;

  logic [1:0]          w_size;
  int                  w_nbytes;
  logic [ADDR_W-1:0]   w_addr_al;
  logic [LANE_W-1:0]   w_lane;
  logic [LANES-1:0]    w_strb;
  logic [DATA_W-1:0]   w_wdata_rep;
  logic                w_cmd;
  logic                w_from_idle;
  logic                w_capture;
  logic                w_trap;
  logic                w_to_done;
  logic [DATA_W-1:0]   w_load_data;

  assign w_cmd       = io.mem_read | io.mem_write;
  assign w_from_idle = (r_state == ST_IDLE);
  assign w_capture   = w_from_idle & io.in_valid;
  assign w_to_done   = (w_next == ST_DONE) && (r_state != ST_DONE);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic w_misal;
  // Any address bit below the access size set means the access is misaligned
  assign w_misal = |(io.mem_addr[LANE_W-1:0] & LANE_W'(w_nbytes - 1));
  assign w_trap  = w_capture & w_cmd & w_misal;
`else
  assign w_trap  = 1'b0;
`endif

  // Request decode: size normalisation, alignment, strobes, store replication
  always_comb begin
    w_size    = eff_size(io.size, DATA_W);
    w_nbytes  = 1 << w_size;
    w_addr_al = io.mem_addr & ~ADDR_W'(w_nbytes - 1);
    w_lane    = w_addr_al[LANE_W-1:0];

    w_strb = '0;
    for (int b = 0; b < LANES; b++) begin
      w_strb[b] = (b >= int'(w_lane)) && (b < int'(w_lane) + w_nbytes);
    end

    case (w_size)
      SIZE_BYTE: w_wdata_rep = {LANES{io.mem_write_data[7:0]}};
      SIZE_HALF: w_wdata_rep = {(LANES/2){io.mem_write_data[15:0]}};
      SIZE_DBL:  w_wdata_rep = io.mem_write_data;
      default:   w_wdata_rep = {(LANES/4){io.mem_write_data[31:0]}};
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (io.in_valid) w_next = (w_cmd && !w_trap) ? ST_REQ : ST_DONE;
      ST_REQ:  if (io.bus_gnt)  w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT: if (io.bus_rvalid) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we          <= 1'b0;
      r_size        <= SIZE_BYTE;
      r_unsigned    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_branch      <= 1'b0;
      r_reg_write   <= 1'b0;
      r_write_reg   <= '0;
      r_branch_addr <= '0;
      r_rwd         <= '0;
    end else if (w_capture) begin
      // A combined read+write command is carried out as a store only
      r_we          <= io.mem_write;
      r_size        <= w_size;
      r_unsigned    <= io.load_unsigned;
      r_addr        <= w_addr_al;
      r_wdata       <= w_wdata_rep;
      r_wstrb       <= w_strb;
      r_branch      <= io.branch_in;
      r_reg_write   <= io.reg_write_in;
      r_write_reg   <= io.write_reg_in;
      r_branch_addr <= io.branch_addr_in;
      r_rwd         <= io.reg_write_data_in;
    end
  end

  load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_align (
    .i_rdata    (io.bus_rdata),
    .i_lane     (r_addr[LANE_W-1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  // Results load on the edge entering DONE. A no-op or trap goes IDLE->DONE
  // directly, so the sideband must then come straight from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_branch      <= 1'b0;
      r_out_reg_write   <= 1'b0;
      r_out_write_reg   <= '0;
      r_out_branch_addr <= '0;
      r_out_rwd         <= '0;
      r_fault           <= 1'b0;
    end else if (w_to_done) begin
      r_out_branch      <= w_from_idle ? io.branch_in      : r_branch;
      r_out_reg_write   <= (w_from_idle ? io.reg_write_in  : r_reg_write) & ~w_trap;
      r_out_write_reg   <= w_from_idle ? io.write_reg_in   : r_write_reg;
      r_out_branch_addr <= w_from_idle ? io.branch_addr_in : r_branch_addr;
      if (r_state == ST_WAIT) begin
        r_out_rwd <= w_load_data;
      end else begin
        r_out_rwd <= w_from_idle ? io.reg_write_data_in : r_rwd;
      end
      r_fault           <= w_trap;
    end
  end

  assign io.in_ready           = (r_state == ST_IDLE);
  assign io.bus_req            = (r_state == ST_REQ);
  assign io.bus_we             = r_we;
  assign io.bus_addr           = r_addr;
  assign io.bus_wdata          = r_wdata;
  assign io.bus_wstrb          = r_wstrb;
  assign io.out_valid          = (r_state == ST_DONE);
  assign io.branch_out         = r_out_branch;
  assign io.reg_write_out      = r_out_reg_write;
  assign io.write_reg_out      = r_out_write_reg;
  assign io.branch_addr_out    = r_out_branch_addr;
  assign io.reg_write_data_out = r_out_rwd;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign_fault = r_fault & (r_state == ST_DONE);
`endif

endmodule

`default_nettype wire
